// File: rtl/if_pkg.sv
//------------------------------------------------------------------------------
// if_pkg : shared types and constants for the instruction-fetch stage
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_pkg;

    localparam logic [31:0] IF_RESET_PC  = 32'hBFC0_0000;
    localparam int          EXC_BUS_ERR  = 0;
    localparam int          EXC_ADDR_ERR = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  exc;
        logic        filled;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_queue.sv
//------------------------------------------------------------------------------
// if_fetch_queue : in-order fetch buffer, entries allocated at request, filled on response
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc,
    input  logic [31:0]            alloc_pc,
    input  logic                   alloc_filled,
    input  logic [1:0]             alloc_exc,
    input  logic                   fill,
    input  logic [31:0]            fill_inst,
    input  logic [1:0]             fill_exc,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   head_valid,
    output logic [31:0]            head_pc,
    output logic [31:0]            head_inst,
    output logic [1:0]             head_exc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    fq_entry_t     mem_d [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d, fp_q, fp_d;
    fq_entry_t     head;

    // fp tracks the oldest allocated entry still waiting for its response
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        fp_d  = fp_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
            fp_d = '0;
        end else begin
            if (alloc) begin
                mem_d[wr_q[AW-1:0]] = '{pc: alloc_pc, inst: 32'h0, exc: alloc_exc, filled: alloc_filled};
                wr_d = wr_q + 1'b1;
                if (alloc_filled && (fp_q == wr_q)) begin
                    fp_d = wr_q + 1'b1;
                end
            end
            if (fill) begin
                mem_d[fp_q[AW-1:0]].inst   = fill_inst;
                mem_d[fp_q[AW-1:0]].exc    = fill_exc;
                mem_d[fp_q[AW-1:0]].filled = 1'b1;
                fp_d = fp_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            fp_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            fp_q  <= fp_d;
        end
    end

    assign head       = mem_q[rd_q[AW-1:0]];
    assign head_valid = (wr_q != rd_q) && head.filled;
    assign head_pc    = head.pc;
    assign head_inst  = head.inst;
    assign head_exc   = head.exc;
    assign count      = wr_q - rd_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
//------------------------------------------------------------------------------
// if_fetch_unit : MIPS IF stage - PC, credit-limited imem requests, redirect/flush
// Optional: IF_ALIGN_CHECK_EN reports misaligned redirect targets as address errors.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
    import if_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter int          FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [1:0]      id_exc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("if_fetch_unit: only XLEN=32 is supported");
        end
        if ((FQ_DEPTH < 2) || (FQ_DEPTH > 16) || ((FQ_DEPTH & (FQ_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("if_fetch_unit: FQ_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            halt_q, halt_d;
    logic            flush, pc_misaligned, credit_ok, req_fire, align_alloc, fill, pop;
    logic [XLEN-1:0] target_sel, target_pc;
    logic [1:0]      alloc_exc, fill_exc;
    logic            head_valid;
    logic [31:0]     head_pc, head_inst;
    logic [1:0]      head_exc;
    logic [CW-1:0]   fq_count;

    assign flush      = exc_valid | redirect_valid;
    assign target_sel = exc_valid ? exc_pc : redirect_pc;

`ifdef IF_ALIGN_CHECK_EN
    assign target_pc     = target_sel;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
    assign target_pc     = target_sel & ~XLEN'(3);
    assign pc_misaligned = 1'b0;
`endif

    // Live in-flight requests already own a queue entry, so only discards add to occupancy
    assign credit_ok      = ({1'b0, fq_count} + {1'b0, discard_q}) < (CW+1)'(FQ_DEPTH);
    assign imem_req_valid = !reset && !flush && credit_ok && !pc_misaligned;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign align_alloc    = !reset && !flush && credit_ok && pc_misaligned && !halt_q;
    assign fill           = imem_resp_valid && !flush && (discard_q == '0);
    assign pop            = head_valid && id_ready;

    always_comb begin
        alloc_exc               = 2'b00;
        alloc_exc[EXC_ADDR_ERR] = align_alloc;
        fill_exc                = 2'b00;
        fill_exc[EXC_BUS_ERR]   = imem_resp_err;
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        discard_d     = discard_q;
        halt_d        = halt_q;
        if (flush) begin
            pc_d      = target_pc;
            discard_d = outstanding_q - CW'(imem_resp_valid);
            halt_d    = 1'b0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (imem_resp_valid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (align_alloc) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            halt_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halt_q        <= halt_d;
        end
    end

    if_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .reset        (reset),
        .alloc        (req_fire | align_alloc),
        .alloc_pc     (pc_q),
        .alloc_filled (align_alloc),
        .alloc_exc    (alloc_exc),
        .fill         (fill),
        .fill_inst    (imem_resp_err ? 32'h0 : imem_resp_data),
        .fill_exc     (fill_exc),
        .pop          (pop),
        .flush        (flush),
        .head_valid   (head_valid),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .head_exc     (head_exc),
        .count        (fq_count)
    );

    assign id_valid = head_valid;
    assign id_inst  = head_valid ? head_inst : '0;
    assign id_pc    = head_valid ? head_pc : '0;
    assign id_exc   = head_valid ? head_exc : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_if_fetch_unit : directed self-checking bench with a fixed-latency imem model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [1:0]  id_exc;

    int          checks;
    int          failures;
    int          cyc;
    int          mem_lat;
    int          req_count;
    logic [31:0] err_addr;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    if_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .exc_valid       (exc_valid),
        .exc_pc          (exc_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_exc          (id_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns ~addr as the instruction word, mem_lat cycles after the handshake
    initial begin : mem_model
        logic [31:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            imem_resp_err   = 1'b0;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                imem_resp_valid = 1'b1;
                imem_resp_data  = ~a;
                imem_resp_err   = (a == err_addr);
            end
            #3;
            if (!reset && imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + mem_lat);
                req_count++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n;
        n = 0;
        while (id_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        ok = (id_valid === 1'b1);
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exc_valid      = 1'b0;
        exc_pc         = 32'h0;
        id_ready       = 1'b0;
        mem_lat        = lat;
        err_addr       = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        reset     = 1'b0;
        req_count = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        reset = 1'b1; redirect_valid = 1'b0; exc_valid = 1'b0; id_ready = 1'b0;
        redirect_pc = 32'h0; exc_pc = 32'h0; mem_lat = 1; err_addr = 32'hFFFF_FFFF;
        step(); step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL reset_id_inst got=%h exp=0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (id_exc !== 2'b00) begin failures++; $display("FAIL reset_id_exc got=%b exp=00", id_exc); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL reset_pc got=%h exp=bfc00000", imem_req_addr); end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hBFC0_0000) begin
            failures++; $display("FAIL first_request got=%b/%h exp=1/bfc00000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1);
        id_ready = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_cycle1_valid got=%b exp=0", id_valid); end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_pc = 32'hBFC0_0000 + 32'(4 * k);
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin
                failures++; $display("FAIL stream_pc[%0d] got=%b/%h exp=1/%h", k, id_valid, id_pc, exp_pc);
            end
            checks++; if (id_inst !== ~exp_pc || id_exc !== 2'b00) begin
                failures++; $display("FAIL stream_inst[%0d] got=%h/%b exp=%h/00", k, id_inst, id_exc, ~exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        bit ok;
        do_reset(1);
        repeat (10) step();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (req_count !== 4) begin failures++; $display("FAIL stall_req_count got=%0d exp=4", req_count); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0000) begin
            failures++; $display("FAIL stall_head got=%b/%h exp=1/bfc00000", id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_pc = 32'hBFC0_0000 + 32'(4 * i);
            wait_valid(20, ok);
            checks++; if (!ok || id_pc !== exp_pc) begin
                failures++; $display("FAIL stall_drain[%0d] got=%b/%h exp=1/%h", i, id_valid, id_pc, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        bit ok;
        do_reset(3);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_req_blocked got=%b exp=0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_id_valid got=%b exp=0", id_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000) begin
            failures++; $display("FAIL redir_req got=%b/%h exp=1/80001000", imem_req_valid, imem_req_addr);
        end
        id_ready = 1'b1;
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_1000 || id_inst !== ~32'h8000_1000) begin
            failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/80001000/%h", id_valid, id_pc, id_inst, ~32'h8000_1000);
        end
        step();
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_1004 || id_inst !== ~32'h8000_1004) begin
            failures++; $display("FAIL redir_second got=%b/%h/%h exp=1/80001004/%h", id_valid, id_pc, id_inst, ~32'h8000_1004);
        end
    endtask

    task automatic test_exc_priority();
        bit ok;
        do_reset(1);
        id_ready = 1'b1;
        repeat (3) step();
        exc_valid      = 1'b1;
        exc_pc         = 32'h8000_0180;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        step();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req_addr !== 32'h8000_0180) begin
            failures++; $display("FAIL exc_next got=%b/%h exp=0/80000180", id_valid, imem_req_addr);
        end
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_0180 || id_inst !== ~32'h8000_0180) begin
            failures++; $display("FAIL exc_first got=%b/%h/%h exp=1/80000180/%h", id_valid, id_pc, id_inst, ~32'h8000_0180);
        end
    endtask

    task automatic test_bus_err();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [1:0]  exp_exc;
        bit ok;
        do_reset(1);
        err_addr = 32'hBFC0_0008;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc   = 32'hBFC0_0000 + 32'(4 * i);
            exp_inst = (i == 2) ? 32'h0 : ~exp_pc;
            exp_exc  = (i == 2) ? 2'b01 : 2'b00;
            wait_valid(20, ok);
            checks++; if (!ok || id_pc !== exp_pc || id_inst !== exp_inst || id_exc !== exp_exc) begin
                failures++; $display("FAIL buserr[%0d] got=%h/%h/%b exp=%h/%h/%b", i, id_pc, id_inst, id_exc, exp_pc, exp_inst, exp_exc);
            end
            step();
        end
    endtask

    task automatic test_align();
        bit ok;
        do_reset(1);
        id_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        step();
        redirect_valid = 1'b0;
        #1;
`ifdef IF_ALIGN_CHECK_EN
        checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            failures++; $display("FAIL align_no_req got=%b/%b exp=0/0", imem_req_valid, id_valid);
        end
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_0002 || id_exc !== 2'b10 || id_inst !== 32'h0) begin
            failures++; $display("FAIL align_entry got=%h/%b/%h exp=80000002/10/0", id_pc, id_exc, id_inst);
        end
        step();
        ok = 1'b1;
        repeat (5) begin
            if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) ok = 1'b0;
            step();
        end
        checks++; if (!ok) begin failures++; $display("FAIL align_stall got=not_idle exp=idle"); end
        exc_valid = 1'b1;
        exc_pc    = 32'h8000_0180;
        step();
        exc_valid = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_0180 || id_exc !== 2'b00) begin
            failures++; $display("FAIL align_resume got=%h/%b exp=80000180/00", id_pc, id_exc);
        end
`else
        checks++; if (imem_req_addr !== 32'h8000_0000) begin
            failures++; $display("FAIL align_forced got=%h exp=80000000", imem_req_addr);
        end
        wait_valid(20, ok);
        checks++; if (!ok || id_pc !== 32'h8000_0000 || id_exc !== 2'b00 || id_inst !== ~32'h8000_0000) begin
            failures++; $display("FAIL align_entry got=%h/%b/%h exp=80000000/00/%h", id_pc, id_exc, id_inst, ~32'h8000_0000);
        end
`endif
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        req_count      = 0;
        mem_lat        = 1;
        err_addr       = 32'hFFFF_FFFF;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exc_valid      = 1'b0;
        exc_pc         = 32'h0;
        id_ready       = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_exc_priority();
        test_bus_err();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
